// File: rtl/addsub_digit_serial.sv
// Digit-serial two's-complement adder/subtractor: WIDTH-bit operands processed
// DIGIT bits per clock through a ripple full-adder digit, with valid/ready handshakes.
module addsub_digit_serial #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             overflow,
    output logic             zero,
    output logic             negative
);

    localparam int NDIG = WIDTH / DIGIT;
    localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;      // B already inverted for subtraction
    logic             cy;       // running carry between digits
    logic [CW-1:0]    cnt;

    logic [DIGIT-1:0] s_dig;
    logic             c_dig;
    logic [WIDTH-1:0] res_nxt;
    logic             last;

    // Ripple the current digit; res_nxt is the result with this digit written in.
    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        logic c;
        logic ai;
        logic bi;
        c     = cy;
        s_dig = '0;
        for (int i = 0; i < DIGIT; i++) begin
            ai       = a_q[int'(cnt) * DIGIT + i];
            bi       = b_q[int'(cnt) * DIGIT + i];
            s_dig[i] = ai ^ bi ^ c;
            c        = (ai & bi) | (c & (ai ^ bi));
        end
        c_dig   = c;
        res_nxt = result;
        res_nxt[int'(cnt) * DIGIT +: DIGIT] = s_dig;
        last    = (int'(cnt) == NDIG - 1);
    end

    // NOTE: operand registers are not reset; they are only read after a capture,
    // so keeping them out of the reset path saves reset fan-out at no risk.
    always_ff @(posedge clk) begin
        if (in_valid && in_ready) begin
            a_q <= a;
            b_q <= b ^ {WIDTH{sub}};
        end
    end

    // NOTE: all state is updated with non-blocking assignments so every register
    // sees the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            cnt       <= '0;
            cy        <= 1'b0;
            result    <= '0;
            carry     <= 1'b0;
            overflow  <= 1'b0;
            zero      <= 1'b0;
            negative  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        cy       <= sub;
                        cnt      <= '0;
                        in_ready <= 1'b0;
                        state    <= BUSY;
                    end
                end
                BUSY: begin
                    result <= res_nxt;
                    cy     <= c_dig;
                    if (last) begin
                        carry     <= c_dig;
                        overflow  <= (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                                     (res_nxt[WIDTH-1] != a_q[WIDTH-1]);
                        zero      <= (res_nxt == '0);
                        negative  <= res_nxt[WIDTH-1];
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_addsub_digit_serial.sv
// Scoreboard bench for addsub_digit_serial: three instances (DIGIT = 1, 4, 16) run
// directed, backpressure, reset and random-stall traffic against a behavioural model.
module tb_addsub_digit_serial;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc     = 0;
    int nchecks = 0;
    int nfail   = 0;
    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchecks++;
        if (obs !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Packed expectation: {result, carry, overflow, zero, negative}.
    function automatic logic [19:0] model(input logic [15:0] x, input logic [15:0] y, input logic s);
        logic [16:0] full;
        logic [15:0] r;
        logic        c;
        int          sr;
        logic        v;
        full = s ? ({1'b0, x} - {1'b0, y}) : ({1'b0, x} + {1'b0, y});
        r    = full[15:0];
        c    = s ? (x >= y) : full[16];
        sr   = s ? (int'($signed(x)) - int'($signed(y))) : (int'($signed(x)) + int'($signed(y)));
        v    = (sr > 32767) || (sr < -32768);
        return {r, c, v, (r == 16'h0), r[15]};
    endfunction

    function automatic logic [15:0] pick();
        case ($urandom_range(0, 5))
            0:       return 16'h0000;
            1:       return 16'hFFFF;
            2:       return 16'h8000;
            3:       return 16'h7FFF;
            default: return 16'($urandom);
        endcase
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int DIG  = (g == 0) ? 1 : (g == 1) ? 4 : 16;
        localparam int NDIG = 16 / DIG;

        logic        rst_n, in_valid, in_ready, sub, out_valid, out_ready;
        logic        carry, overflow, zero, negative;
        logic [15:0] a, b, result;
        logic        hold  = 1'b0;
        logic        rmode = 1'b0;
        logic        done  = 1'b0;
        logic [19:0] exp_q[$];
        int          acc_cyc = 0;
        logic        pv = 1'b0;

        addsub_digit_serial #(.WIDTH(16), .DIGIT(DIG)) dut (
            .clk      (clk),
            .rst_n    (rst_n),
            .in_valid (in_valid),
            .in_ready (in_ready),
            .a        (a),
            .b        (b),
            .sub      (sub),
            .out_valid(out_valid),
            .out_ready(out_ready),
            .result   (result),
            .carry    (carry),
            .overflow (overflow),
            .zero     (zero),
            .negative (negative)
        );

        always @(posedge clk) begin
            #2;
            out_ready = hold ? 1'b0 : (rmode ? ($urandom_range(0, 3) != 0) : 1'b1);
        end

        // Monitor: scoreboard pop on handshake, stall checks, latency, push on accept.
        always @(negedge clk) begin
            logic [19:0] obs;
            obs = {result, carry, overflow, zero, negative};
            if (!rst_n) begin
                exp_q.delete();
                pv = 1'b0;
            end else begin
                if (pv) check($sformatf("d%0d_valid_held", DIG), 32'(out_valid), 32'd1);
                if (out_valid && !pv)
                    check($sformatf("d%0d_latency", DIG), 32'(cyc - acc_cyc), 32'(NDIG));
                if (out_valid) begin
                    if (exp_q.size() == 0) begin
                        check($sformatf("d%0d_spurious_out", DIG), 32'd1, 32'd0);
                        pv = 1'b0;
                    end else if (out_ready) begin
                        check($sformatf("d%0d_result", DIG), 32'(obs), 32'(exp_q.pop_front()));
                        pv = 1'b0;
                    end else begin
                        check($sformatf("d%0d_stall_result", DIG), 32'(obs), 32'(exp_q[0]));
                        check($sformatf("d%0d_stall_in_ready", DIG), 32'(in_ready), 32'd0);
                        pv = 1'b1;
                    end
                end else begin
                    pv = 1'b0;
                end
                if (in_valid && in_ready) begin
                    exp_q.push_back(model(a, b, sub));
                    acc_cyc = cyc + 1;
                end
            end
        end

        // Called just after a posedge; returns just after the accept edge.
        task automatic send(input logic [15:0] ta, input logic [15:0] tb, input logic ts);
            int n;
            n = 0;
            in_valid = 1'b1;
            a = ta;
            b = tb;
            sub = ts;
            do begin
                @(negedge clk);
                n++;
            end while (!in_ready && n < 300);
            if (!in_ready) check($sformatf("d%0d_accept_timeout", DIG), 32'd0, 32'd1);
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            a = 16'($urandom);
            b = 16'($urandom);
            sub = 1'($urandom);
        endtask

        task automatic drain();
            int n;
            n = 0;
            while (exp_q.size() != 0 && n < 5000) begin
                @(posedge clk);
                n++;
            end
            if (exp_q.size() != 0) check($sformatf("d%0d_drain_timeout", DIG), 32'd0, 32'd1);
            #1;
        endtask

        task automatic check_reset_state(input string tag);
            check($sformatf("d%0d_%s", DIG, tag),
                  32'({out_valid, in_ready, result, carry, overflow, zero, negative}),
                  32'({1'b0, 1'b1, 20'h0}));
        endtask

        initial begin
            logic [15:0] va[6];
            logic [15:0] vb[6];
            logic        vs[6];
            int          n;
            va = '{16'h1234, 16'h7FFF, 16'hFFFF, 16'h0005, 16'h0003, 16'h8000};
            vb = '{16'h0FCD, 16'h0001, 16'h0001, 16'h0005, 16'h0005, 16'h0001};
            vs = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
            rst_n = 1'b0;
            in_valid = 1'b0;
            a = '0;
            b = '0;
            sub = 1'b0;
            repeat (2) @(posedge clk);
            @(negedge clk);
            check_reset_state("reset_state");
            @(posedge clk);
            #1;
            rst_n = 1'b1;

            for (int i = 0; i < 6; i++) begin
                send(va[i], vb[i], vs[i]);
                drain();
            end

            // Backpressure: stall in DONE while inputs toggle, then release into a new op.
            hold = 1'b1;
            send(16'h1234, 16'h0FCD, 1'b0);
            n = 0;
            while (!out_valid && n < 100) begin
                @(negedge clk);
                n++;
            end
            check($sformatf("d%0d_bp_reached_done", DIG), 32'(out_valid), 32'd1);
            repeat (5) begin
                @(posedge clk);
                #1;
                in_valid = 1'($urandom);
                a = 16'($urandom);
                b = 16'($urandom);
                sub = 1'($urandom);
            end
            @(posedge clk);
            #1;
            in_valid = 1'b1;
            a = 16'h1111;
            b = 16'h2222;
            sub = 1'b0;
            hold = 1'b0;
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!in_ready && n < 20);
            check($sformatf("d%0d_b2b_gap", DIG), 32'(n), 32'd2);
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            drain();

            // Reset while BUSY aborts the operation.
            send(16'h4321, 16'h1111, 1'b1);
            rst_n = 1'b0;
            @(posedge clk);
            #1;
            rst_n = 1'b1;
            @(negedge clk);
            check_reset_state("mid_busy_reset");
            @(posedge clk);
            #1;
            send(16'h0003, 16'h0005, 1'b1);
            drain();

            rmode = 1'b1;
            repeat (1000) begin
                send(pick(), pick(), 1'($urandom));
                if ($urandom_range(0, 3) == 0) begin
                    @(posedge clk);
                    #1;
                end
            end
            drain();
            rmode = 1'b0;
            done = 1'b1;
        end
    end

    initial begin
        int n;
        n = 0;
        while (!(g_dut[0].done && g_dut[1].done && g_dut[2].done) && n < 90000) begin
            @(posedge clk);
            n++;
        end
        if (!(g_dut[0].done && g_dut[1].done && g_dut[2].done))
            check("global_timeout", 32'd0, 32'd1);
        $display("TB_RESULT checks=%0d failures=%0d", nchecks, nfail);
        $finish;
    end

endmodule
